// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register control: load-use bubbles, branch flushes, memory stalls, debug halt/step.
// Build with PIPE_CTRL_HALT_ON_RESET_EN defined to come out of reset already halted.
module pipeline_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load_use_hazard_i,
    input  logic branch_taken_i,
    input  logic mem_busy_i,
    input  logic dbg_halt_req_i,
    input  logic dbg_resume_req_i,
    input  logic dbg_step_req_i,
    output logic pc_write_en_o,
    output logic if_id_write_en_o,
    output logic global_stall_o,
    output logic global_flush_o,
    output logic if_id_flush_o,
    output logic id_ex_flush_o,
    output logic halted_o,
    output logic step_done_o
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED, STEP} state_e;

    localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

`ifdef PIPE_CTRL_HALT_ON_RESET_EN
    localparam state_e RST_STATE  = HALTED;
    localparam logic   RST_HALTED = 1'b1;
`else
    localparam state_e RST_STATE  = RUN;
    localparam logic   RST_HALTED = 1'b0;
`endif

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       step_active_q, step_active_d;
    logic       halted_q, halted_d;
    logic       step_done_q, step_done_d;
    logic       post_flush_q;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        step_active_d    = step_active_q;
        step_done_d      = 1'b0;
        pc_write_en_o    = 1'b0;
        if_id_write_en_o = 1'b0;
        global_stall_o   = 1'b0;
        if_id_flush_o    = 1'b0;
        id_ex_flush_o    = 1'b0;
        if (rst) begin
            state_d = RST_STATE;
        end else if (mem_busy_i) begin
            global_stall_o = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    pc_write_en_o    = 1'b1;
                    if_id_write_en_o = 1'b1;
                    if (branch_taken_i) begin
                        if_id_flush_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end else if (load_use_hazard_i) begin
                        pc_write_en_o    = 1'b0;
                        if_id_write_en_o = 1'b0;
                        id_ex_flush_o    = 1'b1;
                    end else if (dbg_halt_req_i) begin
                        state_d = DRAIN;
                        cnt_d   = DRAIN_LD;
                    end
                end
                DRAIN: begin
                    if_id_write_en_o = 1'b1;
                    if_id_flush_o    = 1'b1;
                    if (branch_taken_i) begin
                        // Capture the redirect target, then restart the drain
                        pc_write_en_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                        cnt_d         = DRAIN_LD;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_d       = HALTED;
                            step_active_d = 1'b0;
                            step_done_d   = step_active_q;
                        end
                    end
                end
                HALTED: begin
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                    if (dbg_resume_req_i) begin
                        state_d = RUN;
                    end else if (dbg_step_req_i) begin
                        state_d = STEP;
                    end
                end
                STEP: begin
                    pc_write_en_o    = 1'b1;
                    if_id_write_en_o = 1'b1;
                    state_d          = DRAIN;
                    cnt_d            = DRAIN_LD;
                    step_active_d    = 1'b1;
                end
                default: state_d = RUN;
            endcase
        end
        halted_d = (state_d == HALTED);
    end

    assign global_flush_o = rst | post_flush_q;
    assign halted_o       = halted_q;
    assign step_done_o    = step_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RST_STATE;
            cnt_q         <= 4'd0;
            step_active_q <= 1'b0;
            halted_q      <= RST_HALTED;
            step_done_q   <= 1'b0;
            post_flush_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            step_active_q <= step_active_d;
            halted_q      <= halted_d;
            step_done_q   <= step_done_d;
            post_flush_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl against a behavioural model.
// Directed sequences first, then random traffic; every output checked every cycle.
module tb_pipeline_hazard_ctrl;

    localparam int D = 4;
`ifdef PIPE_CTRL_HALT_ON_RESET_EN
    localparam bit HALT_ON_RST = 1'b1;
`else
    localparam bit HALT_ON_RST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, lu, br, busy, halt, resume, step;
    logic pc_we, ifid_we, gstall, gflush, ifid_fl, idex_fl, halted, sdone;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(D)) dut (
        .clk(clk), .rst(rst),
        .load_use_hazard_i(lu), .branch_taken_i(br), .mem_busy_i(busy),
        .dbg_halt_req_i(halt), .dbg_resume_req_i(resume), .dbg_step_req_i(step),
        .pc_write_en_o(pc_we), .if_id_write_en_o(ifid_we),
        .global_stall_o(gstall), .global_flush_o(gflush),
        .if_id_flush_o(ifid_fl), .id_ex_flush_o(idex_fl),
        .halted_o(halted), .step_done_o(sdone)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: where the core is, expressed as plain facts
    bit m_in_reset   = 1'b1;
    bit m_post_flush = 1'b0;
    bit m_halted     = 1'b0;
    int m_drain_left = 0;
    bit m_step_now   = 1'b0;
    bit m_from_step  = 1'b0;
    bit m_done       = 1'b0;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit e_pc, e_ifid, e_stall, e_gfl, e_iffl, e_exfl;
        e_pc = 0; e_ifid = 0; e_stall = 0; e_iffl = 0; e_exfl = 0;
        e_gfl = rst || m_post_flush;
        if (rst) begin
        end else if (busy) begin
            e_stall = 1;
        end else if (m_step_now) begin
            e_pc = 1; e_ifid = 1;
        end else if (m_halted) begin
            e_iffl = 1; e_exfl = 1;
        end else if (m_drain_left > 0) begin
            e_pc = br; e_ifid = 1; e_iffl = 1; e_exfl = br;
        end else if (br) begin
            e_pc = 1; e_ifid = 1; e_iffl = 1; e_exfl = 1;
        end else if (lu) begin
            e_exfl = 1;
        end else begin
            e_pc = 1; e_ifid = 1;
        end
        chk("pc_we", pc_we, e_pc);
        chk("ifid_we", ifid_we, e_ifid);
        chk("stall", gstall, e_stall);
        chk("gflush", gflush, e_gfl);
        chk("ifid_fl", ifid_fl, e_iffl);
        chk("idex_fl", idex_fl, e_exfl);
        if (!m_in_reset) begin
            chk("halted", halted, m_halted);
            chk("step_done", sdone, m_done);
        end
    endtask

    task automatic advance_model();
        if (rst) begin
            m_in_reset = 0; m_post_flush = 1; m_halted = HALT_ON_RST;
            m_drain_left = 0; m_step_now = 0; m_from_step = 0; m_done = 0;
            return;
        end
        m_post_flush = 0;
        if (busy) begin
            m_done = 0;
            return;
        end
        m_done = 0;
        if (m_step_now) begin
            m_step_now = 0; m_drain_left = D; m_from_step = 1;
        end else if (m_halted) begin
            if (resume) m_halted = 0;
            else if (step) begin m_halted = 0; m_step_now = 1; end
        end else if (m_drain_left > 0) begin
            if (br) m_drain_left = D;
            else begin
                m_drain_left--;
                if (m_drain_left == 0) begin
                    m_halted = 1; m_done = m_from_step; m_from_step = 0;
                end
            end
        end else if (halt && !br && !lu) begin
            m_drain_left = D;
        end
    endtask

    // Inputs are set on the falling edge before calling this
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        advance_model();
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input bit l, input bit b, input bit mb,
                         input bit h, input bit rs, input bit st);
        rst = r; lu = l; br = b; busy = mb; halt = h; resume = rs; step = st;
        cycle();
    endtask

    initial begin
        rst = 1; lu = 0; br = 0; busy = 0; halt = 0; resume = 0; step = 0;
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        if (HALT_ON_RST) begin
            repeat (6) drive(0, 0, 0, 0, 0, 0, 0);
            drive(0, 0, 0, 0, 0, 1, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (7) drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            bit h;
            h = ($urandom_range(0, 15) == 0) ? ~halt : halt;
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0,
                  h,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Drives the control side of the pipeline registers: `write_en`, `global_stall` and `global_flush` into the PC register, plus the IF/ID and ID/EX enables and flushes.
- Resolves load-use bubbles, taken-branch redirects and data-memory wait stalls.
- Adds a debug halt/step/resume sequencer that drains the pipeline before reporting halted.
- Sits beside the hazard-detect logic in ID; its outputs fan out to every pipeline register.

Parameters:
- DRAIN_CYCLES, 4, cycles of bubble injection after fetch is frozen before the pipeline counts as empty. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- load_use_hazard_i  in  1  ID needs a bubble (load result not ready).
- branch_taken_i  in  1  EX redirects the PC this cycle.
- mem_busy_i  in  1  data memory not ready; the whole pipeline must freeze.
- dbg_halt_req_i  in  1  level request to halt.
- dbg_resume_req_i  in  1  single-cycle pulse: leave halt.
- dbg_step_req_i  in  1  single-cycle pulse: execute one instruction, then re-halt.
- pc_write_en_o  out  1  PC register `write_en`.
- if_id_write_en_o  out  1  IF/ID register enable.
- global_stall_o  out  1  freeze all pipeline registers.
- global_flush_o  out  1  clear all pipeline registers.
- if_id_flush_o  out  1  turn IF/ID into a NOP.
- id_ex_flush_o  out  1  turn ID/EX into a NOP.
- halted_o  out  1  core halted and pipeline empty (registered).
- step_done_o  out  1  one-cycle pulse when a step completes (registered).

Behaviour:
- State machine: RUN, DRAIN, HALTED, STEP. The drain counter is 4 bits. A step_active flag remembers that the current DRAIN came from a step.
- Reset, while rst=1:
  - State RUN, counter 0, step_active 0, halted_o 0, step_done_o 0.
  - Combinational outputs forced to pc_write_en_o=0, if_id_write_en_o=0, global_flush_o=1, global_stall_o=0, if_id_flush_o=0, id_ex_flush_o=0.
  - global_flush_o stays 1 for exactly one cycle after rst deasserts (registered flag). All other outputs take their state-decoded values from that cycle.
- Priority every cycle, highest first: rst > mem_busy_i > branch_taken_i > load_use_hazard_i > debug requests.
- mem_busy_i=1, any state:
  - global_stall_o=1; pc_write_en_o=0; if_id_write_en_o=0; both flushes 0.
  - State, counter and flags hold.
  - Debug pulses that arrive are lost; the requester must retry.
- RUN:
  - Default outputs: pc_write_en_o=1, if_id_write_en_o=1, everything else 0.
  - branch_taken_i: if_id_flush_o=1 and id_ex_flush_o=1 in the same cycle; pc_write_en_o stays 1 so the redirect loads. A simultaneous load_use_hazard_i is ignored.
  - load_use_hazard_i alone: pc_write_en_o=0, if_id_write_en_o=0, id_ex_flush_o=1 for one bubble cycle per asserted cycle.
  - dbg_halt_req_i=1 and no branch this cycle: next state DRAIN, counter=DRAIN_CYCLES.
- DRAIN:
  - Outputs: pc_write_en_o=0, if_id_write_en_o=1, if_id_flush_o=1.
  - Counter decrements each non-stalled cycle. When it is 1 and decrements, next state is HALTED.
  - branch_taken_i in DRAIN: pc_write_en_o=1 for that cycle so the target is captured; if_id_flush_o=1 and id_ex_flush_o=1; counter reloads to DRAIN_CYCLES.
  - load_use_hazard_i is ignored in DRAIN, because bubbles are already being inserted.
- HALTED:
  - Outputs: halted_o=1, pc_write_en_o=0, if_id_flush_o=1, id_ex_flush_o=1.
  - If step_active was 1 on entry: step_done_o=1 for that first HALTED cycle, then step_active clears.
  - dbg_resume_req_i: next state RUN; halted_o drops the following cycle.
  - dbg_step_req_i with no resume: next state STEP.
  - Resume and step in the same cycle: resume wins.
  - While halted, dbg_halt_req_i level has no effect.
  - RUN is re-entered even if dbg_halt_req_i is still high; it then re-halts on the next cycle.
- STEP:
  - Lasts exactly one cycle: pc_write_en_o=1, if_id_write_en_o=1, no flushes, halted_o=0.
  - Next state DRAIN with counter=DRAIN_CYCLES and step_active=1.
  - Debug requests are ignored in STEP and in a step-initiated DRAIN.
- Reset asserted in any state: returns to the reset values on the next edge; no pulse outputs fire.

Optional Feature:
- Macro: PIPE_CTRL_HALT_ON_RESET_EN.
- When defined:
  - Reset state is HALTED with halted_o=1 from the first cycle after rst releases.
  - The one-cycle post-reset global_flush_o still occurs.
  - The core executes nothing until dbg_resume_req_i or dbg_step_req_i.
- When undefined: reset state is RUN as described above.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release. Required: pc_write_en_o=0 and global_flush_o=1 during reset. global_flush_o=1 for one cycle after release. Then pc_write_en_o=1, if_id_write_en_o=1, halted_o=0.
- Load-use: pulse load_use_hazard_i for 1 cycle in RUN. Required: that cycle pc_write_en_o=0, if_id_write_en_o=0, id_ex_flush_o=1; the next cycle returns to all enables 1.
- Branch vs load-use vs mem_busy:
  - branch_taken_i=1 with load_use_hazard_i=1 → pc_write_en_o=1, if_id_flush_o=1, id_ex_flush_o=1.
  - Add mem_busy_i=1 → global_stall_o=1, pc_write_en_o=0, both flushes 0.
- Halt: raise dbg_halt_req_i in RUN with DRAIN_CYCLES=4. Required: 4 DRAIN cycles with if_id_flush_o=1, then halted_o=1 on the 5th cycle. Inject mem_busy_i for 2 cycles mid-drain → halted_o is delayed exactly 2 cycles.
- Step: from HALTED, pulse dbg_step_req_i. Required: one cycle pc_write_en_o=1, 4 DRAIN cycles, then halted_o=1 with a single step_done_o pulse. Same-cycle resume plus step → RUN, no step_done_o.
- Macro build with PIPE_CTRL_HALT_ON_RESET_EN: release rst. Required: halted_o=1 and pc_write_en_o=0 indefinitely until dbg_resume_req_i; then RUN the next cycle.
